dec_scan_demux: RTL and testbench

//  Parametrised one-hot decoder/demultiplexer with a registered output and an enable.

---
 rtl/dec_scan_demux.sv | 113 +++++++++++
 tb/tb_dec_scan_demux.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/dec_scan_demux.sv
// dec_scan_demux: parametrised one-hot decoder/demultiplexer with a registered
// output and an enable. Besides direct decoding it can auto-scan a single active
// line across all N outputs, holding each line for a programmable dwell time.
//
// Handshake: this block has no valid/ready channel; start is a single-cycle
// request that is accepted only in IDLE with mode=1 and en=1, and busy
// acknowledges it one cycle later.
module dec_scan_demux #(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  mode,
  input  logic                  start,
  input  logic [SEL_W-1:0]      sel,
  input  logic [DWELL_W-1:0]    dwell,
  output logic [2**SEL_W-1:0]   out,
  output logic                  busy,
  output logic                  wrap,
  output logic [1:0]            state_dbg
);

  localparam int N = 2**SEL_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t             state;
  logic [SEL_W-1:0]   idx;
  logic [DWELL_W-1:0] cnt;
  logic [DWELL_W-1:0] dwell_q;

  logic               last_cnt;
  logic [SEL_W-1:0]   idx_step;
  logic [DWELL_W-1:0] cnt_step;

  function automatic logic [N-1:0] onehot(input logic [SEL_W-1:0] i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Next line/count for one scan step: move on once the current line has
  // been shown for dwell_q+1 cycles, wrapping modulo N naturally.
  always_comb begin
    last_cnt = (cnt == dwell_q);
    idx_step = last_cnt ? idx + 1'b1 : idx;
    cnt_step = last_cnt ? '0 : cnt + 1'b1;
  end

  assign state_dbg = state;

  // Main FSM: priority is reset > abort (mode=0) > pause (en=0) > advance.
  // A resume from PAUSE performs a normal step, so the paused line only shows
  // for the cycles it had left.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      out     <= '0;
      busy    <= 1'b0;
      wrap    <= 1'b0;
      idx     <= '0;
      cnt     <= '0;
      dwell_q <= '0;
    end else begin
      wrap <= 1'b0;
      case (state)
        IDLE: begin
          if (mode && en && start) begin
            state   <= SCAN;
            idx     <= sel;
            cnt     <= '0;
            dwell_q <= dwell;
            busy    <= 1'b1;
            out     <= onehot(sel);
          end else begin
            out <= (en && !mode) ? onehot(sel) : '0;
          end
        end
        SCAN, PAUSE: begin
          if (!mode) begin
            state <= IDLE;
            busy  <= 1'b0;
            idx   <= '0;
            cnt   <= '0;
            out   <= en ? onehot(sel) : '0;
          end else if (!en) begin
            state <= PAUSE;
            out   <= '0;
          end else begin
            state <= SCAN;
            idx   <= idx_step;
            cnt   <= cnt_step;
            out   <= onehot(idx_step);
            wrap  <= last_cnt && (idx == '1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          out   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dec_scan_demux.sv
// Testbench for dec_scan_demux: directed steps with a scoreboard queue for the
// 8-line instance, plus a dwell=0 scan sweep over 2-, 8- and 16-line instances.
module tb_dec_scan_demux;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       en, mode, start;
  logic [2:0] sel3;
  logic [3:0] dwell3;

  logic [7:0]  out3;
  logic        busy3, wrap3;
  logic [1:0]  st3;
  logic [1:0]  out1;
  logic        busy1, wrap1;
  logic [1:0]  st1;
  logic [15:0] out4;
  logic        busy4, wrap4;
  logic [1:0]  st4;

  dec_scan_demux #(.SEL_W(3), .DWELL_W(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .start(start),
    .sel(sel3), .dwell(dwell3), .out(out3), .busy(busy3), .wrap(wrap3),
    .state_dbg(st3)
  );

  dec_scan_demux #(.SEL_W(1), .DWELL_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .start(start),
    .sel(1'b0), .dwell(4'd0), .out(out1), .busy(busy1), .wrap(wrap1),
    .state_dbg(st1)
  );

  dec_scan_demux #(.SEL_W(4), .DWELL_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .start(start),
    .sel(4'd0), .dwell(4'd0), .out(out4), .busy(busy4), .wrap(wrap4),
    .state_dbg(st4)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [9:0] exp_q[$];   // {out[7:0], busy, wrap} for dut3

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Drive one cycle of inputs at negedge, queue the expected registered
  // result, then pop and compare just after the following posedge.
  task automatic cyc(input logic e, input logic m, input logic s,
                     input logic [2:0] sl, input logic [3:0] dw,
                     input logic [7:0] eo, input logic eb, input logic ew,
                     input string tag);
    logic [9:0] x;
    @(negedge clk);
    en = e; mode = m; start = s; sel3 = sl; dwell3 = dw;
    exp_q.push_back({eo, eb, ew});
    @(posedge clk);
    #1;
    x = exp_q.pop_front();
    check({tag, "_out"},  {24'd0, out3}, {24'd0, x[9:2]});
    check({tag, "_busy"}, {31'd0, busy3}, {31'd0, x[1]});
    check({tag, "_wrap"}, {31'd0, wrap3}, {31'd0, x[0]});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; en = 1'b0; mode = 1'b0; start = 1'b0; sel3 = '0; dwell3 = '0;

    // Reset state
    cyc(0, 0, 0, 3'd0, 4'd0, 8'h00, 0, 0, "reset");
    cyc(1, 1, 1, 3'd5, 4'd0, 8'h00, 0, 0, "reset_hold");
    check("reset_state", {30'd0, st3}, 32'd0);
    rst_n = 1'b1;

    // T1: direct decode, one-cycle latency, en=0 clears
    for (int i = 0; i < 8; i++)
      cyc(1, 0, 0, 3'(i), 4'd0, 8'(1 << i), 0, 0, "t1_direct");
    cyc(0, 0, 0, 3'd3, 4'd0, 8'h00, 0, 0, "t1_en0");

    // T2: scan from line 6, dwell 2; sel/dwell changes mid-scan are ignored
    cyc(1, 1, 1, 3'd6, 4'd2, 8'h40, 1, 0, "t2_start");
    cyc(1, 1, 0, 3'd1, 4'd9, 8'h40, 1, 0, "t2_l6");
    cyc(1, 1, 0, 3'd1, 4'd9, 8'h40, 1, 0, "t2_l6");
    cyc(1, 1, 0, 3'd0, 4'd0, 8'h80, 1, 0, "t2_l7");
    cyc(1, 1, 0, 3'd0, 4'd0, 8'h80, 1, 0, "t2_l7");
    cyc(1, 1, 0, 3'd0, 4'd0, 8'h80, 1, 0, "t2_l7");
    cyc(1, 1, 0, 3'd0, 4'd0, 8'h01, 1, 1, "t2_wrap");
    cyc(1, 1, 0, 3'd0, 4'd0, 8'h01, 1, 0, "t2_l0");

    // T4: abort mid-scan falls straight back to direct decode
    cyc(1, 0, 0, 3'd5, 4'd0, 8'h20, 0, 0, "t4_abort");
    check("t4_state", {30'd0, st3}, 32'd0);
    cyc(1, 0, 0, 3'd2, 4'd0, 8'h04, 0, 0, "t4_direct");

    // T3: pause after two cycles on line 2 (dwell 3), resume with the rest
    cyc(1, 1, 1, 3'd2, 4'd3, 8'h04, 1, 0, "t3_start");
    cyc(1, 1, 0, 3'd0, 4'd0, 8'h04, 1, 0, "t3_l2");
    cyc(0, 1, 0, 3'd0, 4'd0, 8'h00, 1, 0, "t3_pause");
    check("t3_state", {30'd0, st3}, 32'd2);
    cyc(0, 1, 0, 3'd0, 4'd0, 8'h00, 1, 0, "t3_pause");
    cyc(0, 1, 1, 3'd7, 4'd0, 8'h00, 1, 0, "t3_pause_start");
    cyc(1, 1, 0, 3'd0, 4'd0, 8'h04, 1, 0, "t3_resume");
    cyc(1, 1, 0, 3'd0, 4'd0, 8'h04, 1, 0, "t3_resume");
    cyc(1, 1, 0, 3'd0, 4'd0, 8'h08, 1, 0, "t3_l3");
    cyc(1, 1, 1, 3'd7, 4'd0, 8'h08, 1, 0, "t3_scan_start");

    // T5: reset mid-scan, with a start in the same cycle
    rst_n = 1'b0;
    cyc(1, 1, 1, 3'd1, 4'd0, 8'h00, 0, 0, "t5_rst");
    rst_n = 1'b1;
    cyc(1, 1, 0, 3'd1, 4'd0, 8'h00, 0, 0, "t5_idle");
    cyc(0, 1, 1, 3'd1, 4'd0, 8'h00, 0, 0, "t5_start_en0");
    cyc(1, 0, 1, 3'd4, 4'd0, 8'h10, 0, 0, "t5_start_mode0");

    // T6: dwell 0 sweep on all widths; line advances every cycle
    rst_n = 1'b0;
    cyc(0, 0, 0, 3'd0, 4'd0, 8'h00, 0, 0, "t6_rst");
    rst_n = 1'b1;
    cyc(1, 1, 1, 3'd0, 4'd0, 8'h01, 1, 0, "t6_start");
    check("t6_out1_start", {30'd0, out1}, 32'd1);
    check("t6_out4_start", {16'd0, out4}, 32'd1);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start = 1'b0;
      sel3  = 3'($urandom_range(0, 7));
      @(posedge clk);
      #1;
      check("t6_out1",  {30'd0, out1},  32'(1 << (k % 2)));
      check("t6_wrap1", {31'd0, wrap1}, 32'((k % 2) == 0));
      check("t6_out3",  {24'd0, out3},  32'(1 << (k % 8)));
      check("t6_wrap3", {31'd0, wrap3}, 32'((k % 8) == 0));
      check("t6_out4",  {16'd0, out4},  32'(1 << (k % 16)));
      check("t6_wrap4", {31'd0, wrap4}, 32'((k % 16) == 0));
      check("t6_busy4", {31'd0, busy4}, 32'd1);
      check("t6_onehot", {31'd0, ($onehot0(out1) && $onehot0(out3) && $onehot0(out4))}, 32'd1);
    end

    // ---------------- report ----------------
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: observed %0d entries expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
